// File: rtl/pong_match_ctl.sv
// Pong match sequencer: debounced start/pause button, serve hold, scoring, winner.
// Misses and press act in one cycle with no backpressure; all outputs registered, async active-low reset.
module pong_match_ctl #(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 60,
   parameter int DEB_FRAMES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       button,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_en,
   output logic       ball_rst,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [1:0] winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [3:0] WIN   = 4'(WIN_SCORE);
   localparam logic [7:0] DELAY = 8'(SERVE_DELAY);
   localparam logic [3:0] DEB   = 4'(DEB_FRAMES);

   logic       btn_meta;
   logic       btn_sync;
   logic       btn_lvl;
   logic       btn_lvl_d;
   logic       press;
   logic [3:0] deb_cnt;

   state_t     state_q;
   state_t     state_nxt;
   logic [7:0] serve_cnt;
   logic [7:0] cnt_nxt;
   logic [3:0] sl_nxt;
   logic [3:0] sr_nxt;
   logic [3:0] sl_inc;
   logic [3:0] sr_inc;
   logic [1:0] win_nxt;
   logic       dir_nxt;

   // Accepted level moves only after DEB_FRAMES consecutive differing frame ticks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         btn_lvl   <= 1'b0;
         btn_lvl_d <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         btn_meta  <= button;
         btn_sync  <= btn_meta;
         btn_lvl_d <= btn_lvl;
         if (btn_sync == btn_lvl) begin
            deb_cnt <= '0;
         end else if (frame_tick) begin
            if (deb_cnt + 4'd1 >= DEB) begin
               btn_lvl <= btn_sync;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 4'd1;
            end
         end
      end
   end

   assign press  = btn_lvl & ~btn_lvl_d;
   assign sl_inc = (score_l < WIN) ? score_l + 4'd1 : score_l;
   assign sr_inc = (score_r < WIN) ? score_r + 4'd1 : score_r;

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = serve_cnt;
      sl_nxt    = score_l;
      sr_nxt    = score_r;
      win_nxt   = winner;
      dir_nxt   = serve_dir;
      case (state_q)
         IDLE: begin
            sl_nxt  = '0;
            sr_nxt  = '0;
            win_nxt = 2'b00;
            dir_nxt = 1'b0;
            if (press) begin
               state_nxt = SERVE;
               cnt_nxt   = DELAY;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (serve_cnt <= 8'd1) begin
                  state_nxt = PLAY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = serve_cnt - 8'd1;
               end
            end
         end
         PLAY: begin
            if (miss_left && miss_right) begin
               dir_nxt   = ~serve_dir;
               state_nxt = SERVE;
               cnt_nxt   = DELAY;
            end else if (miss_right) begin
               sl_nxt  = sl_inc;
               dir_nxt = 1'b1;
               if (sl_inc == WIN) begin
                  state_nxt = OVER;
                  win_nxt   = 2'b01;
               end else begin
                  state_nxt = SERVE;
                  cnt_nxt   = DELAY;
               end
            end else if (miss_left) begin
               sr_nxt  = sr_inc;
               dir_nxt = 1'b0;
               if (sr_inc == WIN) begin
                  state_nxt = OVER;
                  win_nxt   = 2'b10;
               end else begin
                  state_nxt = SERVE;
                  cnt_nxt   = DELAY;
               end
            end else if (press) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (press) begin
               state_nxt = PLAY;
            end
         end
         OVER: begin
            if (press) begin
               sl_nxt    = '0;
               sr_nxt    = '0;
               win_nxt   = 2'b00;
               dir_nxt   = 1'b0;
               state_nxt = SERVE;
               cnt_nxt   = DELAY;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Ball controls are registered from the next state so they line up with state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         serve_cnt <= '0;
         score_l   <= '0;
         score_r   <= '0;
         winner    <= 2'b00;
         serve_dir <= 1'b0;
         ball_en   <= 1'b0;
         ball_rst  <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         serve_cnt <= cnt_nxt;
         score_l   <= sl_nxt;
         score_r   <= sr_nxt;
         winner    <= win_nxt;
         serve_dir <= dir_nxt;
         ball_en   <= (state_nxt == PLAY);
         ball_rst  <= (state_nxt == IDLE) || (state_nxt == SERVE) || (state_nxt == OVER);
      end
   end

   assign state = state_q;

endmodule

// File: doc/pong_match_ctl.md
# pong_match_ctl

Match sequencer for the Pong game, clocked on the 65 MHz pixel clock alongside the game/drawing control logic. It turns the player's start button and the ball logic's miss pulses into ball enable/serve controls. It keeps both players' scores, declares the winner and supports pause. Score outputs are binary values that feed the seven-segment driver; the ball and paddle datapaths consume `ball_en`, `ball_rst` and `serve_dir`.

## Interface
- `WIN_SCORE`, 9: points needed to win, 1..15.
- `SERVE_DELAY`, 60: frame ticks the ball is held at centre before a serve, 1..255.
- `DEB_FRAMES`, 2: consecutive frame ticks the synchronised button must be stable before it is accepted, 1..15.

Ports:
- `clk`  in  1  pixel clock (65 MHz).
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `frame_tick`  in  1  one-cycle pulse per frame (start of vblank).
- `button`  in  1  raw board button, asynchronous, active-high.
- `miss_left`  in  1  one-cycle pulse: ball passed left paddle (right player scores).
- `miss_right`  in  1  one-cycle pulse: ball passed right paddle (left player scores).
- `ball_en`  out  1  ball may move.
- `ball_rst`  out  1  hold ball at screen centre.
- `serve_dir`  out  1  0 = serve toward left player, 1 = toward right.
- `score_l`  out  4  left player score.
- `score_r`  out  4  right player score.
- `winner`  out  2  00 none, 01 left, 10 right.
- `state`  out  3  current state code (debug/overlay).

## Operation
- Button path:
  - Two-flop synchroniser, then debounce.
  - The accepted level changes only after the synchronised value differs from it on `DEB_FRAMES` consecutive `frame_tick`s.
  - A change resets the stability counter.
  - `press` is a one-cycle pulse on the accepted level's 0→1 transition.
- States and codes: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4. All other codes return to IDLE.
- IDLE:
  - Scores 0, `winner`=00, `ball_rst`=1, `ball_en`=0.
  - `press` → SERVE; serve counter loaded with `SERVE_DELAY`; `serve_dir`=0.
- SERVE:
  - `ball_rst`=1, `ball_en`=0.
  - Each `frame_tick` decrements the counter.
  - The tick that makes it 0 → PLAY.
  - `press` is ignored.
- PLAY:
  - `ball_rst`=0, `ball_en`=1.
  - `miss_right` alone: `score_l`+1 and `serve_dir`=1.
  - `miss_left` alone: `score_r`+1 and `serve_dir`=0.
  - If the new score equals `WIN_SCORE` → OVER with `winner` set; else → SERVE with the counter reloaded.
  - Both misses in the same cycle: no score change, `serve_dir` toggles, → SERVE.
  - `press` with no miss → PAUSE.
  - Miss and `press` together: the miss wins and `press` is dropped.
- PAUSE:
  - `ball_en`=0, `ball_rst`=0 (ball frozen in place).
  - Misses ignored.
  - `press` → PLAY.
- OVER:
  - `ball_en`=0, `ball_rst`=1; scores and `winner` held.
  - `press`: scores cleared, `winner`=00, `serve_dir`=0, counter reloaded → SERVE.
- Misses outside PLAY are ignored.
- Scores saturate at `WIN_SCORE` and never wrap.
- `frame_tick` coincident with a state entry into SERVE does not decrement; the freshly loaded value is kept.

## Timing
- All outputs registered; outputs reflect the new state in the cycle after the transition's causing input is sampled.
- Button to `press`: 2 sync cycles, plus `DEB_FRAMES` frame ticks, plus 1 cycle for the edge.
- Miss to score/state update: 1 cycle.
- Serve hold: exactly `SERVE_DELAY` `frame_tick`s after SERVE entry; PLAY is visible the cycle after the final tick.
- Reset (asynchronous, any time, including mid-serve or mid-play):
  - state IDLE, `ball_en`=0, `ball_rst`=1, `serve_dir`=0.
  - `score_l`=`score_r`=0, `winner`=00.
  - Synchroniser, debounce and serve counter cleared; accepted button level = 0.
- A button held through reset deassertion produces one `press` after debounce.

## Test plan
- Reset, hold `button`=1 for 3 frame ticks (`DEB_FRAMES`=2) → exactly one `press`; state goes 0→1; `ball_rst`=1; after 60 ticks state=2, `ball_en`=1.
- In PLAY, pulse `miss_right` once → `score_l`=1, `serve_dir`=1, state=1; after 60 ticks state=2.
- `WIN_SCORE`=3, three `miss_left` pulses interleaved with serves → `score_r`=3, `winner`=10, state=4; a further `miss_left` leaves `score_r`=3.
- `miss_left` and `miss_right` in the same cycle with `serve_dir`=0 → scores unchanged, `serve_dir`=1, state=1.
- In PLAY, press → state=3, `ball_en`=0; a `miss_right` pulse → no score change; press again → state=2.
- Button bouncing 1/0 on alternate frame ticks → no `press`; `rst`=0 asserted mid-SERVE → all outputs reach reset values the same cycle, without waiting for a `clk` edge.
